uart_baud_gen: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_gen_frac_acc.sv | 45 ++++
 rtl/uart_baud_gen.sv | 159 +++++++++++++++
 tb/tb_uart_baud_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-rate generator.
//   DEF_DIV_W   : default integer divisor width
//   DEF_OS_RATE : default oversample ticks per baud period (even, >= 2)
//   DEF_FRAC_W  : default fractional divisor width (fractional build only)
//   OS_CNT_W    : width of a counter covering 0..DEF_OS_RATE-1
//   div_t       : integer divisor at the default width
//   frac_t      : fractional divisor at the default width
package uart_pkg;

    localparam int DEF_DIV_W   = 16;
    localparam int DEF_OS_RATE = 16;
    localparam int DEF_FRAC_W  = 4;
    localparam int OS_CNT_W    = $clog2(DEF_OS_RATE);

    typedef logic [DEF_DIV_W-1:0]  div_t;
    typedef logic [DEF_FRAC_W-1:0] frac_t;

endpackage

// File: rtl/uart_baud_gen_frac_acc.sv
// Fractional-divisor accumulator for uart_baud_gen (built only when
// UART_BAUD_FRAC_EN is defined).
// Adds frac at every oversample boundary; a carry out of the accumulator
// raises stretch, which lengthens the following oversample period by one
// clock. stretch holds until the next boundary.
//   clk_i   : system clock
//   reset_n : asynchronous active-low reset
//   clr     : synchronous clear of accumulator and stretch
//   step    : oversample boundary, advance the accumulator
//   frac    : active fractional divisor
//   stretch : next oversample period is one clock longer
`ifdef UART_BAUD_FRAC_EN
module uart_frac_acc
    import uart_pkg::*;
#(
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              step,
    input  logic [FRAC_W-1:0] frac,
    output logic              stretch
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, frac};

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            stretch <= 1'b0;
        end else if (step) begin
            acc     <= sum[FRAC_W-1:0];
            stretch <= sum[FRAC_W];
        end
    end

endmodule
`endif

// File: rtl/uart_baud_gen.sv
// Programmable baud-rate generator for the Avalon-slave UART.
// Divides clk_i by a runtime divisor D into a one-cycle oversample tick,
// a baud tick every OS_RATE oversample ticks, and a 50% baud square wave
// whose rising edge sits mid-bit for RX sampling.
// Optional macro UART_BAUD_FRAC_EN: adds a fractional divisor F so the
// average oversample period is D + F/2^FRAC_W clocks.
//   clk_i       : system clock
//   reset_n     : asynchronous active-low reset
//   en_i        : generator enable (level)
//   div_i       : new integer divisor
//   frac_i      : new fractional divisor (ignored without the macro)
//   div_load_i  : one-cycle pulse, capture div_i/frac_i into the shadow
//   os_tick_o   : oversample tick, one cycle wide
//   baud_tick_o : baud tick, coincident with an os_tick_o
//   clk_o       : baud-rate square wave
//   div_err_o   : active divisor is zero
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int OS_RATE = DEF_OS_RATE,
    parameter int FRAC_W  = DEF_FRAC_W
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              div_load_i,
    output logic              os_tick_o,
    output logic              baud_tick_o,
    output logic              clk_o,
    output logic              div_err_o
);

    localparam int CNT_W = $clog2(OS_RATE);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(OS_RATE - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(OS_RATE / 2);

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic [DIV_W-1:0] div_nxt;
    logic [DIV_W-1:0] term;
    logic [DIV_W-1:0] os_cnt;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_nxt;
    logic             pend;
    logic             run;
    logic             idle;
    logic             boundary;
    logic             apply;
    logic             stretch;

    // idle: generator stopped, either disabled or with no usable divisor.
    // A pending divisor is applied straight away while idle, otherwise only
    // at an oversample boundary so a running period is never cut short.
    assign idle     = !en_i || (div_act == '0);
    assign term     = div_act - DIV_W'(1) + DIV_W'(stretch);
    assign boundary = !idle && run && (os_cnt == term);
    assign apply    = boundary ? (pend || div_load_i) : (idle && pend);
    assign baud_nxt = (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + CNT_W'(1);

    always_comb begin
        div_nxt = div_act;
        if (apply) begin
            div_nxt = (boundary && div_load_i) ? div_i : div_shd;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            div_act   <= '0;
            div_shd   <= '0;
            pend      <= 1'b0;
            div_err_o <= 1'b0;
        end else begin
            div_act   <= div_nxt;
            div_err_o <= (div_nxt == '0);
            if (div_load_i) begin
                div_shd <= div_i;
            end
            // A load coinciding with a boundary is consumed by that boundary.
            if (div_load_i && !boundary) begin
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

    // run spends the first enabled cycle idle so that, counting that cycle
    // as edge 0, the first oversample tick lands after edge D.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            run         <= 1'b0;
            os_cnt      <= '0;
            baud_cnt    <= '0;
            os_tick_o   <= 1'b0;
            baud_tick_o <= 1'b0;
            clk_o       <= 1'b0;
        end else if (idle) begin
            run         <= 1'b0;
            os_cnt      <= '0;
            baud_cnt    <= '0;
            os_tick_o   <= 1'b0;
            baud_tick_o <= 1'b0;
            clk_o       <= 1'b0;
        end else if (!run) begin
            run         <= 1'b1;
            os_tick_o   <= 1'b0;
            baud_tick_o <= 1'b0;
        end else begin
            os_tick_o   <= boundary;
            baud_tick_o <= boundary && (baud_cnt == BAUD_LAST);
            if (boundary) begin
                os_cnt   <= '0;
                baud_cnt <= baud_nxt;
                clk_o    <= (baud_nxt >= BAUD_HALF);
            end else begin
                os_cnt   <= os_cnt + DIV_W'(1);
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_act;
    logic [FRAC_W-1:0] frac_shd;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            frac_act <= '0;
            frac_shd <= '0;
        end else begin
            if (div_load_i) begin
                frac_shd <= frac_i;
            end
            if (apply) begin
                frac_act <= (boundary && div_load_i) ? frac_i : frac_shd;
            end
        end
    end

    uart_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .clr     (idle || apply),
        .step    (boundary),
        .frac    (frac_act),
        .stretch (stretch)
    );
`else
    logic unused_frac;
    assign unused_frac = ^frac_i;
    assign stretch     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen (default parameters D width 16,
// OS_RATE 16). Expected tick edges are queued as stimulus is applied and
// popped as the DUT produces ticks. Edge numbering: the first clock edge
// that samples en_i high is edge 0; outputs are sampled on the falling edge.
module tb_uart_baud_gen;
    import uart_pkg::*;

`ifdef UART_BAUD_FRAC_EN
    localparam int FRAC_SPAN = 144;
`else
    localparam int FRAC_SPAN = 128;
`endif

    logic  clk_i      = 1'b0;
    logic  reset_n    = 1'b0;
    logic  en_i       = 1'b0;
    div_t  div_i      = '0;
    frac_t frac_i     = '0;
    logic  div_load_i = 1'b0;
    logic  os_tick_o;
    logic  baud_tick_o;
    logic  clk_o;
    logic  div_err_o;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_os[$];
    int exp_baud[$];
    int exp_clk[$];

    always #5 clk_i = ~clk_i;

    uart_baud_gen dut (
        .clk_i       (clk_i),
        .reset_n     (reset_n),
        .en_i        (en_i),
        .div_i       (div_i),
        .frac_i      (frac_i),
        .div_load_i  (div_load_i),
        .os_tick_o   (os_tick_o),
        .baud_tick_o (baud_tick_o),
        .clk_o       (clk_o),
        .div_err_o   (div_err_o)
    );

    // Disable, load a divisor, let it apply while disabled, then enable.
    // Returns on the falling edge where en_i has just been raised.
    task automatic setup(input int d, input int f);
        @(negedge clk_i);
        en_i       = 1'b0;
        div_i      = div_t'(d);
        frac_i     = frac_t'(f);
        div_load_i = 1'b1;
        @(negedge clk_i);
        div_load_i = 1'b0;
        @(negedge clk_i);
        en_i       = 1'b1;
        exp_os.delete();
        exp_baud.delete();
        exp_clk.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (os_tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_os_tick: got %b want 0", os_tick_o); end
        n_tests++;
        if (baud_tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_baud_tick: got %b want 0", baud_tick_o); end
        n_tests++;
        if (clk_o !== 1'b0) begin n_fail++; $display("FAIL reset_clk: got %b want 0", clk_o); end
        n_tests++;
        if (div_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_div_err: got %b want 0", div_err_o); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if (div_err_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_div_err: got %b want 1 (D=0)", div_err_o); end
    endtask

    task automatic test_basic();
        int   v;
        logic prev_clk;
        setup(4, 0);
        for (int k = 1; k <= 34; k++) exp_os.push_back(4 * k);
        exp_baud.push_back(64);
        exp_baud.push_back(128);
        for (int k = 1; k <= 4; k++) exp_clk.push_back(32 * k);
        prev_clk = 1'b0;
        for (int e = 0; e < 140; e++) begin
            @(negedge clk_i);
            if (os_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_os.size() > 0) ? exp_os.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL basic_os_tick: tick at edge %0d, expected edge %0d", e, v); end
            end
            if (baud_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_baud.size() > 0) ? exp_baud.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL basic_baud_tick: tick at edge %0d, expected edge %0d", e, v); end
            end
            if (clk_o !== prev_clk) begin
                n_tests++;
                v = (exp_clk.size() > 0) ? exp_clk.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL basic_clk_edge: clk_o toggled at edge %0d, expected edge %0d", e, v); end
                prev_clk = clk_o;
            end
        end
        n_tests++;
        if (exp_os.size() + exp_baud.size() + exp_clk.size() != 0) begin
            n_fail++;
            $display("FAIL basic_missing: %0d expected events never seen, want 0", exp_os.size() + exp_baud.size() + exp_clk.size());
        end
    endtask

    task automatic test_reload();
        int v;
        int want[9] = '{4, 8, 12, 18, 24, 31, 38, 45, 52};
        setup(4, 0);
        foreach (want[i]) exp_os.push_back(want[i]);
        for (int e = 0; e < 56; e++) begin
            @(negedge clk_i);
            if (os_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_os.size() > 0) ? exp_os.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL reload_os_tick: tick at edge %0d, expected edge %0d", e, v); end
            end
            if (e == 9) begin
                div_i = div_t'(6); div_load_i = 1'b1;
            end else if (e == 19) begin
                div_i = div_t'(5); div_load_i = 1'b1;
            end else if (e == 20) begin
                div_i = div_t'(7); div_load_i = 1'b1;
            end else begin
                div_load_i = 1'b0;
            end
        end
        n_tests++;
        if (exp_os.size() != 0) begin n_fail++; $display("FAIL reload_missing: %0d ticks never seen, want 0", exp_os.size()); end
    endtask

    task automatic test_d1();
        int v;
        setup(1, 0);
        for (int k = 1; k < 50; k++) exp_os.push_back(k);
        exp_baud.push_back(16);
        exp_baud.push_back(32);
        exp_baud.push_back(48);
        for (int e = 0; e < 50; e++) begin
            @(negedge clk_i);
            if (os_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_os.size() > 0) ? exp_os.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL d1_os_tick: tick at edge %0d, expected edge %0d", e, v); end
            end
            if (baud_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_baud.size() > 0) ? exp_baud.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL d1_baud_tick: tick at edge %0d, expected edge %0d", e, v); end
            end
        end
        n_tests++;
        if (exp_os.size() + exp_baud.size() != 0) begin
            n_fail++;
            $display("FAIL d1_missing: %0d ticks never seen, want 0", exp_os.size() + exp_baud.size());
        end
    endtask

    task automatic test_div_err();
        int v;
        int early  = 0;
        int hi_clk = 0;
        int first  = -1;
        setup(0, 0);
        for (int e = 0; e < 46; e++) begin
            @(negedge clk_i);
            if (e < 20) begin
                if (os_tick_o === 1'b1 || baud_tick_o === 1'b1) early++;
                if (clk_o === 1'b1) hi_clk++;
            end else if (os_tick_o === 1'b1) begin
                if (first < 0) begin
                    first = e;
                end else begin
                    n_tests++;
                    v = (exp_os.size() > 0) ? exp_os.pop_front() : -1;
                    if (v != e) begin n_fail++; $display("FAIL err_resume_period: tick at edge %0d, expected edge %0d", e, v); end
                end
                exp_os.push_back(e + 3);
            end
            if (e == 19) begin
                n_tests++;
                if (div_err_o !== 1'b1) begin n_fail++; $display("FAIL err_set: div_err_o=%b want 1", div_err_o); end
                div_i = div_t'(3); div_load_i = 1'b1;
            end else begin
                div_load_i = 1'b0;
            end
            if (e == 30) begin
                n_tests++;
                if (div_err_o !== 1'b0) begin n_fail++; $display("FAIL err_clear: div_err_o=%b want 0", div_err_o); end
            end
        end
        n_tests++;
        if (early != 0) begin n_fail++; $display("FAIL err_no_ticks: %0d ticks while D=0, want 0", early); end
        n_tests++;
        if (hi_clk != 0) begin n_fail++; $display("FAIL err_clk_low: clk_o high %0d cycles while D=0, want 0", hi_clk); end
        n_tests++;
        if (first < 0 || first > 30) begin n_fail++; $display("FAIL err_resume: first tick at edge %0d, want within 20..30", first); end
    endtask

    task automatic test_enable();
        int v;
        setup(4, 0);
        for (int e = 0; e < 39; e++) begin
            @(negedge clk_i);
            if (e == 37) begin
                n_tests++;
                if (clk_o !== 1'b1) begin n_fail++; $display("FAIL en_pre_clk: clk_o=%b at baud_cnt 9, want 1", clk_o); end
                en_i = 1'b0;
            end
            if (e == 38) begin
                n_tests++;
                if ({os_tick_o, baud_tick_o, clk_o} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL en_drop_clear: {os,baud,clk}=%b want 000", {os_tick_o, baud_tick_o, clk_o});
                end
                en_i = 1'b1;
            end
        end
        for (int k = 1; k <= 17; k++) exp_os.push_back(4 * k);
        exp_baud.push_back(64);
        for (int e = 0; e < 70; e++) begin
            @(negedge clk_i);
            if (os_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_os.size() > 0) ? exp_os.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL en_restart_os: tick at edge %0d, expected edge %0d", e, v); end
            end
            if (baud_tick_o === 1'b1) begin
                n_tests++;
                v = (exp_baud.size() > 0) ? exp_baud.pop_front() : -1;
                if (v != e) begin n_fail++; $display("FAIL en_restart_baud: tick at edge %0d, expected edge %0d", e, v); end
            end
        end
        n_tests++;
        if (exp_os.size() + exp_baud.size() != 0) begin
            n_fail++;
            $display("FAIL en_missing: %0d ticks never seen, want 0", exp_os.size() + exp_baud.size());
        end
    endtask

    task automatic test_async_reset();
        int late = 0;
        setup(4, 0);
        for (int e = 0; e < 43; e++) begin
            @(negedge clk_i);
            if (e == 41) begin
                div_i = div_t'(2); div_load_i = 1'b1;
            end else begin
                div_load_i = 1'b0;
            end
        end
        n_tests++;
        if (clk_o !== 1'b1) begin n_fail++; $display("FAIL arst_pre_clk: clk_o=%b want 1", clk_o); end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({os_tick_o, baud_tick_o, clk_o, div_err_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL arst_clear: {os,baud,clk,err}=%b want 0000", {os_tick_o, baud_tick_o, clk_o, div_err_o});
        end
        @(negedge clk_i);
        reset_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk_i);
            if (os_tick_o === 1'b1) late++;
        end
        n_tests++;
        if (late != 0) begin n_fail++; $display("FAIL arst_pending_dropped: %0d ticks after reset, want 0", late); end
        n_tests++;
        if (div_err_o !== 1'b1) begin n_fail++; $display("FAIL arst_div_err: div_err_o=%b want 1", div_err_o); end
    endtask

    task automatic test_frac();
        int n  = 0;
        int t1 = -1;
        int t33 = -1;
        setup(4, 8);
        for (int e = 0; e < 200; e++) begin
            @(negedge clk_i);
            if (os_tick_o === 1'b1) begin
                n++;
                if (n == 1) t1 = e;
                if (n == 33) t33 = e;
            end
        end
        n_tests++;
        if (t33 < 0 || (t33 - t1) != FRAC_SPAN) begin
            n_fail++;
            $display("FAIL frac_span: 32 os periods took %0d cycles, want %0d", (t33 < 0) ? -1 : t33 - t1, FRAC_SPAN);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_d1();
        test_div_err();
        test_enable();
        test_async_reset();
        test_frac();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
